// File: rtl/tm_buffer_drain.sv
// tm_buffer_drain: drains Tm even/odd result-buffer pairs through port B and
// streams {odd, even} feature pairs on a valid/ready interface, ordered
// pixel-address-major, channel-minor.
// Optional build macro: TM_DRAIN_RELU_EN (clamp negative halves to zero).
module tm_buffer_drain #(
  parameter int unsigned Tm            = 8,
  parameter int unsigned FEATURE_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned CH_WIDTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_WIDTH:0]           num_pixels,
  output logic [Tm-1:0]                 buf_rd_en,
  output logic [ADDR_WIDTH-1:0]         buf_rd_addr,
  input  logic [Tm*FEATURE_WIDTH-1:0]   buf_rd_data_even,
  input  logic [Tm*FEATURE_WIDTH-1:0]   buf_rd_data_odd,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*FEATURE_WIDTH-1:0]    out_data,
  output logic [CH_WIDTH-1:0]           out_ch,
  output logic [ADDR_WIDTH-1:0]         out_addr,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned FW = FEATURE_WIDTH;
  localparam int unsigned DW = 2 * FEATURE_WIDTH;
  localparam logic [CH_WIDTH-1:0] CH_LAST = CH_WIDTH'(Tm - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  typedef struct packed {
    logic [DW-1:0]         data;
    logic [CH_WIDTH-1:0]   ch;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  last;
  } entry_t;

  logic [1:0]            state_q, state_d;
  logic                  busy_d, done_d;
  logic                  load_c, issue_c, last_c, pop_c, push_c, flush_ok_c;
  logic [1:0]            occ_c;

  logic [ADDR_WIDTH-1:0] addr_q, n_m1_q;
  logic [CH_WIDTH-1:0]   ch_q;

  logic                  rd_vld_q;
  logic [CH_WIDTH-1:0]   rd_ch_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  rd_last_q;

  logic [FW-1:0]         even_c, odd_c, even_p, odd_p;
  entry_t                push_entry_c;

  entry_t                head_q, tail_q;
  logic                  head_vld_q, tail_vld_q;

  // Occupancy after this cycle's pop; issue keeps occupancy + in-flight <= 2
  always_comb begin
    pop_c      = head_vld_q & out_ready;
    push_c     = rd_vld_q;
    occ_c      = 2'(head_vld_q) + 2'(tail_vld_q) - 2'(pop_c);
    last_c     = (addr_q == n_m1_q) && (ch_q == CH_LAST);
    issue_c    = (state_q == S_RUN) && ((occ_c + 2'(rd_vld_q)) < 2'd2);
    flush_ok_c = !rd_vld_q && (occ_c == 2'd0);
  end

  // Port-B request: one-hot enable for the issuing channel, shared address
  always_comb begin
    buf_rd_en = '0;
    for (int unsigned i = 0; i < Tm; i++) begin
      buf_rd_en[i] = issue_c && (ch_q == CH_WIDTH'(i));
    end
    buf_rd_addr = addr_q;
  end

  // FSM state, busy and done registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // FSM next state; zero-length drains complete straight from IDLE
  always_comb begin
    state_d = state_q;
    busy_d  = busy;
    done_d  = 1'b0;
    load_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_pixels != '0) begin
            load_c  = 1'b1;
            busy_d  = 1'b1;
            state_d = S_RUN;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (issue_c && last_c) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (flush_ok_c) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Issue counters and in-flight read tracking; counters stop on the last read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      ch_q      <= '0;
      n_m1_q    <= '0;
      rd_vld_q  <= 1'b0;
      rd_ch_q   <= '0;
      rd_addr_q <= '0;
      rd_last_q <= 1'b0;
    end else begin
      rd_vld_q <= issue_c;
      if (issue_c) begin
        rd_ch_q   <= ch_q;
        rd_addr_q <= addr_q;
        rd_last_q <= last_c;
      end
      if (load_c) begin
        addr_q <= '0;
        ch_q   <= '0;
        n_m1_q <= ADDR_WIDTH'(num_pixels - 1'b1);
      end else if (issue_c && !last_c) begin
        if (ch_q == CH_LAST) begin
          ch_q   <= '0;
          addr_q <= addr_q + 1'b1;
        end else begin
          ch_q   <= ch_q + 1'b1;
        end
      end
    end
  end

  // Select the returning channel's data and build the FIFO entry
  always_comb begin
    even_c = '0;
    odd_c  = '0;
    for (int unsigned i = 0; i < Tm; i++) begin
      if (rd_ch_q == CH_WIDTH'(i)) begin
        even_c = buf_rd_data_even[i*FW +: FW];
        odd_c  = buf_rd_data_odd[i*FW +: FW];
      end
    end
    even_p = even_c;
    odd_p  = odd_c;
`ifdef TM_DRAIN_RELU_EN
    if (even_c[FW-1]) even_p = '0;
    if (odd_c[FW-1])  odd_p  = '0;
`endif
    push_entry_c.data = {odd_p, even_p};
    push_entry_c.ch   = rd_ch_q;
    push_entry_c.addr = rd_addr_q;
    push_entry_c.last = rd_last_q;
  end

  // Two-entry output FIFO; head register drives the stream directly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      head_vld_q <= 1'b0;
      tail_vld_q <= 1'b0;
    end else begin
      case ({push_c, pop_c})
        2'b10: begin
          if (!head_vld_q) begin
            head_q     <= push_entry_c;
            head_vld_q <= 1'b1;
          end else begin
            tail_q     <= push_entry_c;
            tail_vld_q <= 1'b1;
          end
        end
        2'b01: begin
          head_q     <= tail_q;
          head_vld_q <= tail_vld_q;
          tail_vld_q <= 1'b0;
        end
        2'b11: begin
          if (tail_vld_q) begin
            head_q <= tail_q;
            tail_q <= push_entry_c;
          end else begin
            head_q <= push_entry_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = head_vld_q;
  assign out_data  = head_q.data;
  assign out_ch    = head_q.ch;
  assign out_addr  = head_q.addr;
  assign out_last  = head_q.last;

endmodule

// File: tb/tb_tm_buffer_drain.sv
// tb_tm_buffer_drain: scoreboard bench for tm_buffer_drain with a behavioural
// 1-cycle-latency port-B RAM model.
`timescale 1ns/1ps
module tb_tm_buffer_drain;

  localparam int TM = 8;
  localparam int FW = 16;
  localparam int AW = 10;
  localparam int CW = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [AW:0]        num_pixels = '0;
  logic [TM-1:0]      buf_rd_en;
  logic [AW-1:0]      buf_rd_addr;
  logic [TM*FW-1:0]   dob_even = '0;
  logic [TM*FW-1:0]   dob_odd = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [2*FW-1:0]    out_data;
  logic [CW-1:0]      out_ch;
  logic [AW-1:0]      out_addr;
  logic               out_last;
  logic               busy;
  logic               done;

  always #5 clk = ~clk;

  tm_buffer_drain #(.Tm(TM), .FEATURE_WIDTH(FW), .ADDR_WIDTH(AW), .CH_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_pixels(num_pixels),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
    .buf_rd_data_even(dob_even), .buf_rd_data_odd(dob_odd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_addr(out_addr), .out_last(out_last),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [2*FW-1:0] data;
    logic [CW-1:0]   ch;
    logic [AW-1:0]   addr;
    logic            last;
  } word_t;

  word_t exp_q[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // Buffer contents: ramp pattern (mode 0) or fixed signed pair (mode 1)
  int data_mode = 0;
  function automatic logic [FW-1:0] ev(input int ch, input int addr);
    if (data_mode == 1) return 16'hFFF0;
    return FW'(ch * 256 + addr);
  endfunction
  function automatic logic [FW-1:0] od(input int ch, input int addr);
    if (data_mode == 1) return 16'h0010;
    return FW'(ch * 256 + addr + 'h1000);
  endfunction
  function automatic logic [FW-1:0] relu(input logic [FW-1:0] x);
`ifdef TM_DRAIN_RELU_EN
    if (x[FW-1]) return '0;
`endif
    return x;
  endfunction

  // Port-B RAM model: registered read on enable, output held otherwise
  always @(posedge clk) begin
    for (int i = 0; i < TM; i++) begin
      if (buf_rd_en[i]) begin
        dob_even[i*FW +: FW] <= ev(i, int'(buf_rd_addr));
        dob_odd[i*FW +: FW]  <= od(i, int'(buf_rd_addr));
      end
    end
  end

  int cyc = 0, words = 0, issued_n = 0, accepted_n = 0, done_cnt = 0, exp_total = 0;
  int start_cyc = -1, first_valid_cyc = -1, first_acc_cyc = -1, last_acc_cyc = -1, done_cyc = -1;
  bit valid_seen = 0, busy_seen = 0, prev_stall = 0;
  word_t prev_w, last_w, first_w;

  // Monitor: issue order, outstanding limit, stall stability, scoreboard
  always @(negedge clk) begin
    word_t w, e;
    bit acc;
    logic [TM-1:0] een;
    cyc++;
    if (rst) begin
      prev_stall = 0;
    end else begin
      w.data = out_data; w.ch = out_ch; w.addr = out_addr; w.last = out_last;
      acc = out_valid && out_ready;
      if (start && !busy) start_cyc = cyc;
      if (busy) busy_seen = 1;
      if (out_valid) begin
        valid_seen = 1;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (prev_stall) check("hold", 64'({out_valid, w}), 64'({1'b1, prev_w}));
      prev_stall = out_valid && !out_ready;
      prev_w = w;
      if (buf_rd_en != '0) begin
        een = '0;
        een[issued_n % TM] = 1'b1;
        check("issue", 64'({buf_rd_addr, buf_rd_en}), 64'({AW'(issued_n / TM), een}));
        check("outstanding", 64'((issued_n - accepted_n - int'(acc)) < 2), 64'(1));
        issued_n++;
      end
      if (acc) begin
        if (first_acc_cyc < 0) begin
          first_acc_cyc = cyc;
          first_w = w;
        end
        last_acc_cyc = cyc;
        last_w = w;
        if (exp_q.size() == 0) begin
          check("extra_word", 64'(words + 1), 64'(exp_total));
        end else begin
          e = exp_q.pop_front();
          check("word", 64'(w), 64'(e));
        end
        if (words == 9 && data_mode == 0 && exp_total == 32)
          check("word9", 64'(out_data), 64'h1101_0101);
        words++;
        accepted_n++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_at_done", 64'(busy), 64'(0));
      end
    end
  end

  int ready_mode = 0;
  int rphase = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    rphase++;
    if (ready_mode == 0) out_ready = 1'b1;
    else out_ready = ((rphase % 4) == 0) || ((rphase % 4) == 3);
  endtask

  task automatic clear_stats();
    words = 0; issued_n = 0; accepted_n = 0;
    first_valid_cyc = -1; first_acc_cyc = -1; last_acc_cyc = -1;
    valid_seen = 0; busy_seen = 0;
    exp_q.delete();
  endtask

  task automatic do_start(input int n);
    word_t e;
    clear_stats();
    exp_total = n * TM;
    for (int a = 0; a < n; a++) begin
      for (int c = 0; c < TM; c++) begin
        e.data = {relu(od(c, a)), relu(ev(c, a))};
        e.ch   = CW'(c);
        e.addr = AW'(a);
        e.last = (a == n - 1) && (c == TM - 1);
        exp_q.push_back(e);
      end
    end
    start = 1'b1;
    num_pixels = (AW+1)'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != d0) break;
      tick();
    end
    check(tag, 64'(done_cnt - d0), 64'(1));
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_out", 64'({out_valid, out_data, out_ch, out_addr, out_last}), 64'(0));
    check("rst_ctl", 64'({busy, done, buf_rd_en, buf_rd_addr}), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Full-rate drain of 4 pixels
    ready_mode = 0;
    do_start(4);
    wait_done(200, "t1_done");
    check("t1_latency", 64'(first_valid_cyc - start_cyc), 64'(3));
    check("t1_rate", 64'(last_acc_cyc - first_acc_cyc), 64'(31));
    check("t1_done_lat", 64'(done_cyc - last_acc_cyc), 64'(1));
    check("t1_words", 64'(words), 64'(32));
    check("t1_left", 64'(exp_q.size()), 64'(0));
    check("t1_last", 64'({last_w.addr, last_w.ch, last_w.last}), 64'({10'd3, 4'd7, 1'b1}));
    tick();

    // Backpressure 1-0-0-1 plus an ignored start while busy
    ready_mode = 1;
    rphase = 0;
    do_start(4);
    repeat (6) tick();
    start = 1'b1;
    num_pixels = 11'd1;
    tick();
    start = 1'b0;
    wait_done(400, "t2_done");
    check("t2_words", 64'(words), 64'(32));
    check("t2_left", 64'(exp_q.size()), 64'(0));
    ready_mode = 0;
    repeat (3) tick();

    // Zero-length drain
    d0 = done_cnt;
    do_start(0);
    repeat (4) tick();
    check("t3_done_cnt", 64'(done_cnt - d0), 64'(1));
    check("t3_done_lat", 64'(done_cyc - start_cyc), 64'(1));
    check("t3_issue", 64'(issued_n), 64'(0));
    check("t3_valid", 64'(valid_seen), 64'(0));
    check("t3_busy", 64'(busy_seen), 64'(0));

    // Full-depth drain of 1024 pixels
    do_start(1024);
    wait_done(9000, "t4_done");
    check("t4_words", 64'(words), 64'(8192));
    check("t4_issues", 64'(issued_n), 64'(8192));
    check("t4_last", 64'({last_w.addr, last_w.ch, last_w.last}), 64'({10'd1023, 4'd7, 1'b1}));
    tick();

    // Reset mid-drain, then a fresh drain
    do_start(4);
    for (int i = 0; i < 100; i++) begin
      if (words >= 10) break;
      tick();
    end
    check("t5_reach10", 64'(words >= 10), 64'(1));
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("t5_rst_out", 64'({out_valid, out_data, out_ch, out_addr, out_last}), 64'(0));
    check("t5_rst_ctl", 64'({busy, done, buf_rd_en}), 64'(0));
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("t5_no_done", 64'(done_cnt - d0), 64'(0));
    do_start(2);
    wait_done(200, "t5_done");
    check("t5_words", 64'(words), 64'(16));
    check("t5_first", 64'({first_w.addr, first_w.ch}), 64'(0));
    tick();

    // Signed data: ReLU clamps the negative even half when enabled
    data_mode = 1;
    do_start(1);
    wait_done(100, "t6_done");
`ifdef TM_DRAIN_RELU_EN
    check("t6_relu", 64'(last_w.data), 64'h0010_0000);
`else
    check("t6_relu", 64'(last_w.data), 64'h0010_FFF0);
`endif
    check("t6_words", 64'(words), 64'(8));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
